// File: rtl/ima_adpcm_pkg.sv
// Shared IMA ADPCM constants, the 89-entry step table and the index-delta rule.
package ima_adpcm_pkg;

  localparam int IMA_MAX_INDEX = 88;
  localparam int PRED_W        = 19;
  localparam int STEP_W        = 15;

  localparam logic [STEP_W-1:0] STEP_TABLE [0:IMA_MAX_INDEX] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  // Indices past the table end behave like the last entry.
  function automatic logic [STEP_W-1:0] stepSize(input logic [6:0] index);
    if (index > 7'(IMA_MAX_INDEX)) return '1;
    return STEP_TABLE[index];
  endfunction

  // Small magnitudes walk the step index down, large ones jump it up.
  function automatic logic signed [4:0] indexDelta(input logic [2:0] mag);
    case (mag)
      3'd4:    return 5'sd2;
      3'd5:    return 5'sd4;
      3'd6:    return 5'sd6;
      3'd7:    return 5'sd8;
      default: return -5'sd1;
    endcase
  endfunction

endpackage

// File: rtl/ima_adpcm_core.sv
// Combinational IMA ADPCM decode step: one nibble against one channel's state.
module ima_adpcm_core
  import ima_adpcm_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [PRED_W-1:0]    predIn,
  input  logic        [6:0]           idxIn,
  input  logic        [3:0]           nibble,
  output logic signed [PRED_W-1:0]    predOut,
  output logic        [6:0]           idxOut,
  output logic signed [OUT_WIDTH-1:0] samp
);

  // Two guard bits: pred plus the largest dq exceeds a 20-bit signed range.
  function automatic logic signed [PRED_W-1:0] satPred(input logic signed [PRED_W+1:0] s);
    if (s > 21'sd262143)  return 19'sh3FFFF;
    if (s < -21'sd262144) return 19'sh40000;
    return s[PRED_W-1:0];
  endfunction

  // Round half up at the first dropped fraction bit, then clip to OUT_WIDTH.
  function automatic logic signed [OUT_WIDTH-1:0] roundSat(input logic signed [PRED_W-1:0] p);
    logic signed [OUT_WIDTH:0] pre;
    pre = $signed({p[PRED_W-1], p[PRED_W-1 -: OUT_WIDTH]})
        + $signed({{OUT_WIDTH{1'b0}}, p[PRED_W-1-OUT_WIDTH]});
    if (!pre[OUT_WIDTH] && pre[OUT_WIDTH-1]) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    if (pre[OUT_WIDTH] && !pre[OUT_WIDTH-1]) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    return pre[OUT_WIDTH-1:0];
  endfunction

  logic        [STEP_W-1:0] step;
  logic        [PRED_W-1:0] dq;
  logic signed [PRED_W+1:0] predSum;
  logic signed [4:0]        delta;
  logic signed [8:0]        idxSum;

  // Dequantise, update predictor and index, derive the output sample.
  always_comb begin
    step    = stepSize(idxIn);
    dq      = PRED_W'(step) * PRED_W'({nibble[2:0], 1'b1});
    if (nibble[3])
      predSum = {{2{predIn[PRED_W-1]}}, predIn} - $signed({2'b00, dq});
    else
      predSum = {{2{predIn[PRED_W-1]}}, predIn} + $signed({2'b00, dq});
    predOut = satPred(predSum);
    delta   = indexDelta(nibble[2:0]);
    idxSum  = $signed({2'b00, idxIn}) + $signed({{4{delta[4]}}, delta});
    if (idxSum < 9'sd0)
      idxOut = 7'd0;
    else if (idxSum > 9'sd88)
      idxOut = 7'(IMA_MAX_INDEX);
    else
      idxOut = idxSum[6:0];
    samp    = roundSat(predOut);
  end

endmodule

// File: rtl/ima_adpcm_mc_dec.sv
// Multi-channel IMA ADPCM decoder: per-channel state, handshakes, output register.
module ima_adpcm_mc_dec
  import ima_adpcm_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic        [3:0]           inPCM,
  input  logic        [CH_W-1:0]      inChan,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic        [CH_W-1:0]      ldChan,
  input  logic signed [15:0]          ldPredictSamp,
  input  logic        [6:0]           ldStepIndex,
  input  logic                        ldValid,
  output logic signed [OUT_WIDTH-1:0] outSamp,
  output logic        [CH_W-1:0]      outChan,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        errChan
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

  logic signed [PRED_W-1:0]    predMem [NUM_CH];
  logic        [6:0]           idxMem  [NUM_CH];

  logic                        inChanOk;
  logic                        ldChanOk;
  logic                        accept;
  logic                        vld_p0;
  logic signed [PRED_W-1:0]    selPred_p0;
  logic        [6:0]           selIdx_p0;
  logic signed [PRED_W-1:0]    newPred_p0;
  logic        [6:0]           newIdx_p0;
  logic signed [OUT_WIDTH-1:0] samp_p0;
  logic        [6:0]           ldIdx;

  // A pending load owns the state port, so inputs wait for it.
  assign inReady  = !ldValid && (!outValid || outReady);
  assign accept   = inValid && inReady;
  assign inChanOk = {1'b0, inChan} < NUM_CH_V;
  assign ldChanOk = {1'b0, ldChan} < NUM_CH_V;
  assign vld_p0   = accept && inChanOk;
  assign ldIdx    = (ldStepIndex > 7'(IMA_MAX_INDEX)) ? 7'(IMA_MAX_INDEX) : ldStepIndex;

  // Read the addressed channel's state; unknown channels read as zero.
  always_comb begin
    selPred_p0 = '0;
    selIdx_p0  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (inChan == CH_W'(c)) begin
        selPred_p0 = predMem[c];
        selIdx_p0  = idxMem[c];
      end
    end
  end

  ima_adpcm_core #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .predIn  (selPred_p0),
    .idxIn   (selIdx_p0),
    .nibble  (inPCM),
    .predOut (newPred_p0),
    .idxOut  (newIdx_p0),
    .samp    (samp_p0)
  );

  // Channel state: loads and decodes never coincide because loads stall inputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        predMem[c] <= '0;
        idxMem[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ldValid && ldChan == CH_W'(c)) begin
          predMem[c] <= {ldPredictSamp, 3'b000};
          idxMem[c]  <= ldIdx;
        end else if (vld_p0 && inChan == CH_W'(c)) begin
          predMem[c] <= newPred_p0;
          idxMem[c]  <= newIdx_p0;
        end
      end
    end
  end

  // ---- stage p1: output register, held under backpressure ----
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      outSamp  <= '0;
      outChan  <= '0;
      outValid <= 1'b0;
      errChan  <= 1'b0;
    end else begin
      errChan <= (accept && !inChanOk) || (ldValid && !ldChanOk);
      if (vld_p0) begin
        outSamp  <= samp_p0;
        outChan  <= inChan;
        outValid <= 1'b1;
      end else if (outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ima_adpcm_mc_dec.sv
// Self-checking bench for ima_adpcm_mc_dec with a reference model and scoreboard queue.
module tb_ima_adpcm_mc_dec;

  logic               clock = 1'b0;
  logic               resetN;
  logic        [3:0]  inPCM;
  logic        [1:0]  inChan;
  logic               inValid;
  logic               inReady;
  logic        [1:0]  ldChan;
  logic signed [15:0] ldPredictSamp;
  logic        [6:0]  ldStepIndex;
  logic               ldValid;
  logic signed [15:0] outSamp;
  logic        [1:0]  outChan;
  logic               outValid;
  logic               outReady;
  logic               errChan;

  ima_adpcm_mc_dec #(
    .NUM_CH    (2),
    .CH_W      (2),
    .OUT_WIDTH (16)
  ) dut (
    .clock         (clock),
    .resetN        (resetN),
    .inPCM         (inPCM),
    .inChan        (inChan),
    .inValid       (inValid),
    .inReady       (inReady),
    .ldChan        (ldChan),
    .ldPredictSamp (ldPredictSamp),
    .ldStepIndex   (ldStepIndex),
    .ldValid       (ldValid),
    .outSamp       (outSamp),
    .outChan       (outChan),
    .outValid      (outValid),
    .outReady      (outReady),
    .errChan       (errChan)
  );

  always #5 clock = ~clock;

  localparam int NO_LIT = 100000;

  int vectors     = 0;
  int miscompares = 0;

  int STEP_TAB [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767};
  int IDX_ADJ [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  int mPred [0:3];
  int mIdx  [0:3];

  typedef struct {int ch; int samp;} exp_t;
  typedef struct {int ch; int nib; int lit;} stim_t;
  exp_t sbq [$];

  task automatic modelReset();
    for (int c = 0; c < 4; c++) begin
      mPred[c] = 0;
      mIdx[c]  = 0;
    end
    sbq.delete();
  endtask

  task automatic modelLoad(input int ch, input int p, input int ix);
    mPred[ch] = p * 8;
    mIdx[ch]  = (ix > 88) ? 88 : ix;
  endtask

  task automatic modelDecode(input int ch, input int nib, output int samp);
    int mag, dq, p;
    mag = nib & 7;
    dq  = STEP_TAB[mIdx[ch]] * (2 * mag + 1);
    p   = ((nib & 8) != 0) ? mPred[ch] - dq : mPred[ch] + dq;
    if (p > 262143)  p = 262143;
    if (p < -262144) p = -262144;
    mPred[ch] = p;
    mIdx[ch]  = mIdx[ch] + IDX_ADJ[mag];
    if (mIdx[ch] < 0)  mIdx[ch] = 0;
    if (mIdx[ch] > 88) mIdx[ch] = 88;
    samp = (p >>> 3) + ((p >>> 2) & 1);
    if (samp > 32767)  samp = 32767;
    if (samp < -32768) samp = -32768;
  endtask

  // Drive one input; in-range channels get their expected output queued.
  task automatic send(input int ch, input int nib);
    int s;
    inChan  = 2'(ch);
    inPCM   = 4'(nib);
    inValid = 1'b1;
    if (ch < 2) begin
      modelDecode(ch, nib, s);
      sbq.push_back('{ch: ch, samp: s});
    end
  endtask

  function automatic exp_t nextExp();
    exp_t e;
    if (sbq.size() > 0) e = sbq.pop_front();
    else begin
      e.ch   = 3;
      e.samp = 0;
    end
    return e;
  endfunction

  task automatic idle();
    inValid = 1'b0;
    ldValid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; outReady = 1'b1; idle();
    inChan = '0; inPCM = '0; ldChan = '0; ldPredictSamp = '0; ldStepIndex = '0;
    modelReset();
    tick(); tick();
    vectors++;
    if (outValid !== 1'b0 || outSamp !== 16'sd0 || outChan !== 2'd0 || errChan !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b samp=%0d chan=%0d err=%0b, want 0 0 0 0",
               outValid, outSamp, outChan, errChan);
    end
    resetN = 1'b1;
    tick();
    vectors++;
    if (inReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_inReady: got %0b want 1", inReady);
    end
  endtask

  task automatic test_basic_decode();
    stim_t tab [6] = '{'{0, 7, 13}, '{1, 7, 13}, '{0, 15, -17}, '{0, 1, NO_LIT},
                       '{1, 12, NO_LIT}, '{0, 6, NO_LIT}};
    exp_t e;
    foreach (tab[i]) begin
      send(tab[i].ch, tab[i].nib);
      tick();
      idle();
      e = nextExp();
      vectors++;
      if (outValid !== 1'b1 || outSamp !== 16'(e.samp) || outChan !== 2'(e.ch)) begin
        miscompares++;
        $display("FAIL basic[%0d]: valid=%0b samp=%0d chan=%0d, want samp=%0d chan=%0d",
                 i, outValid, outSamp, outChan, e.samp, e.ch);
      end
      if (tab[i].lit != NO_LIT) begin
        vectors++;
        if (outSamp !== 16'(tab[i].lit)) begin
          miscompares++;
          $display("FAIL basic_lit[%0d]: samp=%0d want %0d", i, outSamp, tab[i].lit);
        end
      end
    end
    tick();
    vectors++;
    if (outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: outValid=%0b want 0", outValid);
    end
  endtask

  task automatic test_saturation();
    stim_t tab [3] = '{'{0, 7, 32767}, '{0, 15, -28670}, '{0, 15, -32768}};
    exp_t e;
    ldChan = 2'd0; ldPredictSamp = 16'sh7FF0; ldStepIndex = 7'd88; ldValid = 1'b1;
    modelLoad(0, 32752, 88);
    tick();
    ldValid = 1'b0;
    foreach (tab[i]) begin
      send(tab[i].ch, tab[i].nib);
      tick();
      idle();
      e = nextExp();
      vectors++;
      if (outValid !== 1'b1 || outSamp !== 16'(e.samp) || outSamp !== 16'(tab[i].lit)) begin
        miscompares++;
        $display("FAIL sat[%0d]: valid=%0b samp=%0d, want %0d (model %0d)",
                 i, outValid, outSamp, tab[i].lit, e.samp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   lit [5] = '{1, 2, 3, 4, 4};
    exp_t e;
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    modelReset();
    for (int i = 0; i < 5; i++) begin
      send(1, 0);
      tick();
      e = nextExp();
      vectors++;
      if (outValid !== 1'b1 || outSamp !== 16'(lit[i]) || outSamp !== 16'(e.samp) ||
          outChan !== 2'd1) begin
        miscompares++;
        $display("FAIL idx_clamp[%0d]: valid=%0b samp=%0d chan=%0d, want %0d chan 1",
                 i, outValid, outSamp, outChan, lit[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      send(i % 2, (i * 5) % 16);
      tick();
      e = nextExp();
      vectors++;
      if (outValid !== 1'b1 || outSamp !== 16'(e.samp) || outChan !== 2'(e.ch)) begin
        miscompares++;
        $display("FAIL b2b_mix[%0d]: valid=%0b samp=%0d chan=%0d, want samp=%0d chan=%0d",
                 i, outValid, outSamp, outChan, e.samp, e.ch);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    outReady = 1'b0;
    send(0, 4);
    tick();
    send(1, 5);
    #1;
    vectors++;
    if (inReady !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_inReady: got %0b want 0", inReady);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (outValid !== 1'b1 || outSamp !== 16'(sbq[0].samp) || outChan !== 2'd0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%0b samp=%0d chan=%0d, want samp=%0d chan=0",
                 i, outValid, outSamp, outChan, sbq[0].samp);
      end
      tick();
    end
    ldChan = 2'd0; ldPredictSamp = 16'sd500; ldStepIndex = 7'd10; ldValid = 1'b1;
    modelLoad(0, 500, 10);
    tick();
    ldValid = 1'b0;
    e = nextExp();
    vectors++;
    if (outValid !== 1'b1 || outSamp !== 16'(e.samp) || outChan !== 2'(e.ch)) begin
      miscompares++;
      $display("FAIL bp_first: valid=%0b samp=%0d chan=%0d, want samp=%0d chan=%0d",
               outValid, outSamp, outChan, e.samp, e.ch);
    end
    outReady = 1'b1;
    #1;
    vectors++;
    if (inReady !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: inReady=%0b want 1", inReady);
    end
    tick();
    inValid = 1'b0;
    e = nextExp();
    vectors++;
    if (outValid !== 1'b1 || outSamp !== 16'(e.samp) || outChan !== 2'(e.ch)) begin
      miscompares++;
      $display("FAIL bp_second: valid=%0b samp=%0d chan=%0d, want samp=%0d chan=%0d",
               outValid, outSamp, outChan, e.samp, e.ch);
    end
    tick();
    vectors++;
    if (outValid !== 1'b0 || sbq.size() != 0) begin
      miscompares++;
      $display("FAIL bp_empty: outValid=%0b pending=%0d, want 0 0", outValid, sbq.size());
    end
    send(0, 2);
    tick();
    idle();
    e = nextExp();
    vectors++;
    if (outValid !== 1'b1 || outSamp !== 16'(e.samp)) begin
      miscompares++;
      $display("FAIL bp_loaded: valid=%0b samp=%0d, want %0d", outValid, outSamp, e.samp);
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    outReady = 1'b1;
    ldChan = 2'd1; ldPredictSamp = 16'sd1000; ldStepIndex = 7'd20; ldValid = 1'b1;
    modelLoad(1, 1000, 20);
    send(1, 3);
    #1;
    vectors++;
    if (inReady !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_inReady: got %0b want 0", inReady);
    end
    tick();
    ldValid = 1'b0;
    vectors++;
    if (outValid !== 1'b0 || errChan !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_no_out: valid=%0b err=%0b, want 0 0", outValid, errChan);
    end
    tick();
    inValid = 1'b0;
    e = nextExp();
    vectors++;
    if (outValid !== 1'b1 || outSamp !== 16'(e.samp) || outSamp !== 16'sd1044) begin
      miscompares++;
      $display("FAIL ld_then_in: valid=%0b samp=%0d, want 1044 (model %0d)",
               outValid, outSamp, e.samp);
    end
    ldChan = 2'd3; ldPredictSamp = 16'sd1234; ldStepIndex = 7'd40; ldValid = 1'b1;
    tick();
    ldValid = 1'b0;
    vectors++;
    if (errChan !== 1'b1 || outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_badchan: err=%0b valid=%0b, want 1 0", errChan, outValid);
    end
    tick();
    vectors++;
    if (errChan !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse_len: err=%0b want 0", errChan);
    end
    send(2, 7);
    tick();
    idle();
    vectors++;
    if (errChan !== 1'b1 || outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL in_badchan: err=%0b valid=%0b, want 1 0", errChan, outValid);
    end
    ldChan = 2'd0; ldPredictSamp = -16'sd100; ldStepIndex = 7'd120; ldValid = 1'b1;
    modelLoad(0, -100, 120);
    tick();
    ldValid = 1'b0;
    send(1, 0);
    tick();
    e = nextExp();
    vectors++;
    if (outValid !== 1'b1 || outSamp !== 16'(e.samp) || outChan !== 2'd1) begin
      miscompares++;
      $display("FAIL ch1_untouched: valid=%0b samp=%0d chan=%0d, want %0d chan 1",
               outValid, outSamp, outChan, e.samp);
    end
    send(0, 0);
    tick();
    idle();
    e = nextExp();
    vectors++;
    if (outValid !== 1'b1 || outSamp !== 16'(e.samp) || outSamp !== 16'sd3996) begin
      miscompares++;
      $display("FAIL ld_idx_clamp: valid=%0b samp=%0d, want 3996 (model %0d)",
               outValid, outSamp, e.samp);
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    outReady = 1'b0;
    send(1, 7);
    tick();
    idle();
    vectors++;
    if (outValid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pending: outValid=%0b want 1", outValid);
    end
    #2;
    resetN = 1'b0;
    #1;
    vectors++;
    if (outValid !== 1'b0 || outSamp !== 16'sd0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%0b samp=%0d, want 0 0", outValid, outSamp);
    end
    modelReset();
    tick();
    resetN   = 1'b1;
    outReady = 1'b1;
    tick();
    for (int ch = 0; ch < 2; ch++) begin
      send(ch, 7);
      tick();
      idle();
      e = nextExp();
      vectors++;
      if (outValid !== 1'b1 || outSamp !== 16'sd13 || outSamp !== 16'(e.samp) ||
          outChan !== 2'(ch)) begin
        miscompares++;
        $display("FAIL post_reset[%0d]: valid=%0b samp=%0d chan=%0d, want 13 chan %0d",
                 ch, outValid, outSamp, outChan, ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_load_priority();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
